// File: rtl/popcount_pkg.sv
// Shared constants and width helpers for the pipelined population counter.
package popcount_pkg;

  localparam int ACC_W_DEF = 16;

  // Bits needed to hold a count in the range 0..n.
  function automatic int clog2_p1(input int n);
    return $clog2(n + 1);
  endfunction

  // Adder-tree depth for a w-bit word; one registered level per tree level.
  function automatic int lat_of(input int w);
    return $clog2(w);
  endfunction

  // Bit offset of tree level k inside the flat tree bus for a p-bit padded word.
  // Level j holds (p >> j) sums of (j + 1) bits each.
  function automatic int lvl_off(input int p, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) off += (p >> j) * (j + 1);
    return off;
  endfunction

endpackage

// File: rtl/popcount_if.sv
// Streaming handshake bundle for popcount_pipe: word in, count out.
interface popcount_if import popcount_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CW    = clog2_p1(WIDTH)
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;
  logic             out_all;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, out_zero, out_all
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, out_zero, out_all
  );

endinterface

// File: rtl/popcount_stage.sv
// One registered level of the popcount adder tree: sums adjacent operand pairs.
module popcount_stage import popcount_pkg::*; #(
  parameter int PAIRS = 1,
  parameter int IW    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      vld_in,
  input  logic [2*PAIRS-1:0][IW-1:0] d,
  output logic                      vld_out,
  output logic [PAIRS-1:0][IW:0]    q
);

  // Register pair sums and the slot valid bit; hold everything when not advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_out <= 1'b0;
      q       <= '0;
    end else if (en) begin
      vld_out <= vld_in;
      for (int i = 0; i < PAIRS; i++)
        q[i] <= {1'b0, d[2*i]} + {1'b0, d[2*i+1]};
    end
  end

endmodule

// File: rtl/popcount_pipe.sv
// Pipelined WIDTH-bit population counter with valid/ready on both sides.
// The input is zero-padded to 2^LAT bits and reduced by LAT registered adder
// levels that all advance together. Optional running accumulator of delivered
// counts is compiled in with POPCOUNT_ACC_EN.
module popcount_pipe import popcount_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CW    = clog2_p1(WIDTH),
  parameter int LAT   = lat_of(WIDTH),
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  popcount_if.slave        bus
`ifdef POPCOUNT_ACC_EN
  ,
  input  logic             acc_clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_sat
`endif
);

  localparam int P   = 1 << LAT;
  localparam int TOT = lvl_off(P, LAT + 1);

  // All tree levels packed back to back; level 0 is the padded input word.
  logic [TOT-1:0] tree;
  logic [LAT:0]   vld_pipe;
  logic [LAT:0]   fin;
  logic           adv;

  // Whole pipe moves when the output slot is empty or being consumed; bubbles
  // travel like data so ordering and latency stay fixed.
  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  assign tree[P-1:0]  = P'(bus.in_data);
  assign vld_pipe[0]  = bus.in_valid;

  for (genvar k = 1; k <= LAT; k++) begin : g_lvl
    localparam int IOFF = lvl_off(P, k - 1);
    localparam int OOFF = lvl_off(P, k);
    popcount_stage #(.PAIRS(P >> k), .IW(k)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .vld_in  (vld_pipe[k-1]),
      .d       (tree[IOFF +: (P >> (k - 1)) * k]),
      .vld_out (vld_pipe[k]),
      .q       (tree[OOFF +: (P >> k) * (k + 1)])
    );
  end

  // Final level is a single LAT+1 bit sum; its value never exceeds WIDTH.
  assign fin           = tree[lvl_off(P, LAT) +: LAT + 1];
  assign bus.out_valid = vld_pipe[LAT];
  assign bus.out_count = CW'(fin);
  assign bus.out_zero  = (fin == '0);
  assign bus.out_all   = (fin == (LAT + 1)'(WIDTH));

`ifdef POPCOUNT_ACC_EN
  logic             hs;
  logic [ACC_W:0]   acc_sum;

  assign hs = bus.out_valid & bus.out_ready;

  // Next accumulator value with one spare bit to detect overflow; a clear
  // restarts the sum from zero in the same cycle as any handshake.
  always_comb begin
    acc_sum = acc_clr ? '0 : {1'b0, acc_out};
    if (hs) acc_sum = acc_sum + (ACC_W + 1)'(bus.out_count);
  end

  // Saturating accumulate with a sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
      acc_sat <= 1'b0;
    end else if (hs || acc_clr) begin
      acc_out <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
      acc_sat <= (acc_sat & ~acc_clr) | acc_sum[ACC_W];
    end
  end
`endif

endmodule

// File: tb/tb_popcount_pipe.sv
// Self-checking bench for popcount_pipe: WIDTH=8 and WIDTH=13 instances,
// directed scenarios plus a randomized stream scored against $countones.
module tb_popcount_pipe;
  import popcount_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  popcount_if #(.WIDTH(8))  b8 ();
  popcount_if #(.WIDTH(13)) b13 ();

`ifdef POPCOUNT_ACC_EN
  logic        acc_clr8  = 1'b0;
  logic        acc_clr13 = 1'b0;
  logic [3:0]  acc_out8;
  logic        acc_sat8;
  logic [15:0] acc_out13;
  logic        acc_sat13;
  popcount_pipe #(.WIDTH(8), .ACC_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8),
    .acc_clr(acc_clr8), .acc_out(acc_out8), .acc_sat(acc_sat8));
  popcount_pipe #(.WIDTH(13)) dut13 (
    .clk(clk), .rst_n(rst_n), .bus(b13),
    .acc_clr(acc_clr13), .acc_out(acc_out13), .acc_sat(acc_sat13));
`else
  popcount_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  popcount_pipe #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(b13));
`endif

  task automatic drive8(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    b8.in_valid = v; b8.in_data = d; b8.out_ready = r;
    #1;
  endtask

  task automatic drive13(input logic v, input logic [12:0] d, input logic r);
    @(negedge clk);
    b13.in_valid = v; b13.in_data = d; b13.out_ready = r;
    #1;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid8 got=%0b want=0", b8.out_valid); end
    total++; if (b8.out_count !== 4'd0) begin bad++; $display("FAIL rst_count8 got=%0d want=0", b8.out_count); end
    total++; if (b8.out_zero !== 1'b1) begin bad++; $display("FAIL rst_zero8 got=%0b want=1", b8.out_zero); end
    total++; if (b8.out_all !== 1'b0) begin bad++; $display("FAIL rst_all8 got=%0b want=0", b8.out_all); end
    total++; if (b13.out_valid !== 1'b0 || b13.out_zero !== 1'b1) begin bad++; $display("FAIL rst_13 got=%0b/%0b want=0/1", b13.out_valid, b13.out_zero); end
`ifdef POPCOUNT_ACC_EN
    total++; if (acc_out8 !== 4'd0 || acc_sat8 !== 1'b0) begin bad++; $display("FAIL rst_acc8 got=%0d/%0b want=0/0", acc_out8, acc_sat8); end
    total++; if (acc_out13 !== 16'd0 || acc_sat13 !== 1'b0) begin bad++; $display("FAIL rst_acc13 got=%0d/%0b want=0/0", acc_out13, acc_sat13); end
`endif
    @(negedge clk); rst_n = 1'b1;
    #1;
    total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready8 got=%0b want=1", b8.in_ready); end
    total++; if (b13.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready13 got=%0b want=1", b13.in_ready); end
  endtask

  task automatic test_back_to_back;
    drive8(1'b1, 8'hFF, 1'b1);
    drive8(1'b1, 8'h00, 1'b1);
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early got=%0b want=0", b8.out_valid); end
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (b8.out_valid !== 1'b1 || b8.out_count !== 4'd8) begin bad++; $display("FAIL b2b_ff got=%0b/%0d want=1/8", b8.out_valid, b8.out_count); end
    total++; if (b8.out_all !== 1'b1 || b8.out_zero !== 1'b0) begin bad++; $display("FAIL b2b_ff_flags got=%0b/%0b want=1/0", b8.out_all, b8.out_zero); end
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (b8.out_valid !== 1'b1 || b8.out_count !== 4'd0) begin bad++; $display("FAIL b2b_00 got=%0b/%0d want=1/0", b8.out_valid, b8.out_count); end
    total++; if (b8.out_zero !== 1'b1 || b8.out_all !== 1'b0) begin bad++; $display("FAIL b2b_00_flags got=%0b/%0b want=1/0", b8.out_zero, b8.out_all); end
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%0b want=0", b8.out_valid); end
  endtask

  task automatic test_stall;
    logic [7:0] words [4] = '{8'h01, 8'h03, 8'h07, 8'hA5};
    int         want  [4] = '{1, 2, 3, 4};
    int         got[$];
    int         sent = 0, cyc = 0, stalls = 0;
    logic       r, prev_stall = 1'b0;
    logic [3:0] prev_cnt = '0;
    while (got.size() < 4 && cyc < 40) begin
      r = !(cyc >= 2 && cyc <= 5);
      drive8(sent < 4, words[(sent < 4) ? sent : 0], r);
      if (b8.out_valid && !r) begin
        stalls++;
        total++; if (b8.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready cyc=%0d got=%0b want=0", cyc, b8.in_ready); end
        if (prev_stall) begin
          total++; if (b8.out_count !== prev_cnt) begin bad++; $display("FAIL stall_hold cyc=%0d got=%0d want=%0d", cyc, b8.out_count, prev_cnt); end
        end
        prev_cnt = b8.out_count;
      end
      prev_stall = b8.out_valid && !r;
      if (b8.in_valid && b8.in_ready) sent++;
      if (b8.out_valid && r) got.push_back(int'(b8.out_count));
      cyc++;
    end
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (stalls != 3) begin bad++; $display("FAIL stall_cycles got=%0d want=3", stalls); end
    total++; if (got.size() != 4) begin bad++; $display("FAIL stall_delivered got=%0d want=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++; if (got[i] != want[i]) begin bad++; $display("FAIL stall_order idx=%0d got=%0d want=%0d", i, got[i], want[i]); end
    end
  endtask

  task automatic test_width13;
    drive13(1'b1, 13'h1FFF, 1'b1);
    drive13(1'b1, 13'h1000, 1'b1);
    drive13(1'b0, 13'h0, 1'b1);
    drive13(1'b0, 13'h0, 1'b1);
    total++; if (b13.out_valid !== 1'b0) begin bad++; $display("FAIL w13_early got=%0b want=0", b13.out_valid); end
    drive13(1'b0, 13'h0, 1'b1);
    total++; if (b13.out_valid !== 1'b1 || b13.out_count !== 4'd13 || b13.out_all !== 1'b1) begin bad++; $display("FAIL w13_full got=%0b/%0d/%0b want=1/13/1", b13.out_valid, b13.out_count, b13.out_all); end
    drive13(1'b0, 13'h0, 1'b1);
    total++; if (b13.out_valid !== 1'b1 || b13.out_count !== 4'd1 || b13.out_all !== 1'b0 || b13.out_zero !== 1'b0) begin bad++; $display("FAIL w13_one got=%0b/%0d/%0b/%0b want=1/1/0/0", b13.out_valid, b13.out_count, b13.out_all, b13.out_zero); end
    drive13(1'b0, 13'h0, 1'b1);
  endtask

  task automatic test_reset_inflight;
    int seen = 0;
    drive8(1'b1, 8'h11, 1'b1);
    drive8(1'b1, 8'h33, 1'b1);
    drive8(1'b1, 8'h77, 1'b1);
    drive8(1'b0, 8'h00, 1'b1);
    total++; if (b8.out_valid !== 1'b1) begin bad++; $display("FAIL rif_pre got=%0b want=1", b8.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (b8.out_valid !== 1'b0 || b8.out_count !== 4'd0) begin bad++; $display("FAIL rif_drop got=%0b/%0d want=0/0", b8.out_valid, b8.out_count); end
    total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL rif_ready got=%0b want=1", b8.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive8(1'b0, 8'h00, 1'b1);
      if (b8.out_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rif_stale got=%0d want=0", seen); end
  endtask

`ifdef POPCOUNT_ACC_EN
  task automatic test_acc;
    @(negedge clk); acc_clr8 = 1'b1; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    @(negedge clk); acc_clr8 = 1'b0;
    #1;
    total++; if (acc_out8 !== 4'd0 || acc_sat8 !== 1'b0) begin bad++; $display("FAIL acc_clear got=%0d/%0b want=0/0", acc_out8, acc_sat8); end
    drive8(1'b1, 8'hFF, 1'b1);
    drive8(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) drive8(1'b0, 8'h00, 1'b1);
    total++; if (acc_out8 !== 4'd15 || acc_sat8 !== 1'b1) begin bad++; $display("FAIL acc_sat got=%0d/%0b want=15/1", acc_out8, acc_sat8); end
    drive8(1'b1, 8'h0F, 1'b1);
    drive8(1'b0, 8'h00, 1'b1);
    drive8(1'b0, 8'h00, 1'b1);
    @(negedge clk); acc_clr8 = 1'b1; b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    #1;
    total++; if (b8.out_valid !== 1'b1 || b8.out_count !== 4'd4) begin bad++; $display("FAIL acc_pre got=%0b/%0d want=1/4", b8.out_valid, b8.out_count); end
    @(negedge clk); acc_clr8 = 1'b0;
    #1;
    total++; if (acc_out8 !== 4'd4 || acc_sat8 !== 1'b0) begin bad++; $display("FAIL acc_clr_hs got=%0d/%0b want=4/0", acc_out8, acc_sat8); end
  endtask
`endif

  task automatic test_random;
    int q8[$], q13[$];
    int sent8 = 0, sent13 = 0, got8 = 0, got13 = 0, cyc = 0, exp;
    while ((sent8 < 1000 || sent13 < 1000 || q8.size() > 0 || q13.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      b8.in_valid   = (sent8 < 1000) && ($urandom_range(0, 9) < 7);
      b8.in_data    = 8'($urandom);
      b8.out_ready  = ($urandom_range(0, 9) < 7);
      b13.in_valid  = (sent13 < 1000) && ($urandom_range(0, 9) < 7);
      b13.in_data   = 13'($urandom);
      b13.out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (b8.out_valid && b8.out_ready) begin
        got8++;
        exp = (q8.size() > 0) ? q8.pop_front() : -1;
        total++;
        if (int'(b8.out_count) != exp || b8.out_zero !== (exp == 0) || b8.out_all !== (exp == 8)) begin
          bad++; $display("FAIL rnd8 n=%0d got=%0d/%0b/%0b want=%0d", got8, b8.out_count, b8.out_zero, b8.out_all, exp);
        end
      end
      if (b13.out_valid && b13.out_ready) begin
        got13++;
        exp = (q13.size() > 0) ? q13.pop_front() : -1;
        total++;
        if (int'(b13.out_count) != exp || b13.out_zero !== (exp == 0) || b13.out_all !== (exp == 13)) begin
          bad++; $display("FAIL rnd13 n=%0d got=%0d/%0b/%0b want=%0d", got13, b13.out_count, b13.out_zero, b13.out_all, exp);
        end
      end
      if (b8.in_valid && b8.in_ready)   begin q8.push_back($countones(b8.in_data));   sent8++;  end
      if (b13.in_valid && b13.in_ready) begin q13.push_back($countones(b13.in_data)); sent13++; end
      cyc++;
    end
    total++; if (got8 != 1000 || got13 != 1000) begin bad++; $display("FAIL rnd_count got=%0d/%0d want=1000/1000 cycles=%0d", got8, got13, cyc); end
    drive8(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.out_ready  = 1'b1;
    b13.in_valid = 1'b0; b13.in_data = '0; b13.out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_stall();
    test_width13();
    test_reset_inflight();
`ifdef POPCOUNT_ACC_EN
    test_acc();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
